// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and encodings for the retire monitor
package riscv_pkg;

  localparam logic [31:0] HALT_INST0_DEF = 32'h00c00093;
  localparam logic [31:0] HALT_INST1_DEF = 32'h00008067;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_e;

  typedef enum logic [1:0] {
    SEL_RD   = 2'd0,
    SEL_BR   = 2'd1,
    SEL_ST   = 2'd2,
    SEL_HOLD = 2'd3
  } out_sel_e;

  // A write to x0 does not count as a write.
  function automatic out_sel_e pick_out_sel(input logic rd_we, input logic [4:0] rd_wa,
                                            input logic is_branch, input logic is_store);
    if (rd_we && (rd_wa != 5'd0)) return SEL_RD;
    else if (is_branch)           return SEL_BR;
    else if (is_store)            return SEL_ST;
    else                          return SEL_HOLD;
  endfunction

endpackage

// File: rtl/riscv_halt_detect.sv
// rtl/riscv_halt_detect.sv - two-instruction halt idiom detector (IDLE/ARMED/HALTED)
module riscv_halt_detect
  import riscv_pkg::*;
#(
  parameter logic [31:0] HALT_INST0 = HALT_INST0_DEF,
  parameter logic [31:0] HALT_INST1 = HALT_INST1_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_inst,
  output logic        o_halted,
  output logic        o_accept
);

  halt_state_e r_state;
  logic        r_halted;
  logic        w_accept;

  assign w_accept = i_valid && (r_state != ST_HALTED);
  assign o_accept = w_accept;
  assign o_halted = r_halted;

  // Bubbles leave the state alone, so stalls between the pair keep ARMED.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_halted <= 1'b0;
    end else if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (i_inst == HALT_INST0) r_state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (i_inst == HALT_INST1) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else if (i_inst != HALT_INST0) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

endmodule

// File: rtl/riscv_retire_monitor.sv
// rtl/riscv_retire_monitor.sv - retired-instruction counter, observable result and halt flag
module riscv_retire_monitor
  import riscv_pkg::*;
#(
  parameter int          CNT_WIDTH  = 32,
  parameter logic [31:0] HALT_INST0 = HALT_INST0_DEF,
  parameter logic [31:0] HALT_INST1 = HALT_INST1_DEF
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 RETIRE_VALID,
  input  logic [31:0]          RETIRE_INST,
  input  logic                 RETIRE_RD_WE,
  input  logic [4:0]           RETIRE_RD_WA,
  input  logic [31:0]          RETIRE_RD_WD,
  input  logic                 RETIRE_IS_BRANCH,
  input  logic                 RETIRE_BR_TAKEN,
  input  logic                 RETIRE_IS_STORE,
  input  logic [31:0]          RETIRE_MEM_ADDR,
  output logic [CNT_WIDTH-1:0] NUM_INST,
  output logic [31:0]          OUTPUT_PORT,
  output logic                 HALT
);

  logic                 w_accept;
  logic                 w_halted;
  out_sel_e             w_sel;
  logic [CNT_WIDTH-1:0] r_num_inst;
  logic [31:0]          r_output_port;

  riscv_halt_detect #(
    .HALT_INST0 (HALT_INST0),
    .HALT_INST1 (HALT_INST1)
  ) u_halt_detect (
    .i_clk    (CLK),
    .i_rst_n  (RSTn),
    .i_valid  (RETIRE_VALID),
    .i_inst   (RETIRE_INST),
    .o_halted (w_halted),
    .o_accept (w_accept)
  );

  assign w_sel = pick_out_sel(RETIRE_RD_WE, RETIRE_RD_WA, RETIRE_IS_BRANCH, RETIRE_IS_STORE);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_num_inst    <= '0;
      r_output_port <= '0;
    end else if (w_accept) begin
      if (r_num_inst != {CNT_WIDTH{1'b1}})
        r_num_inst <= r_num_inst + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      case (w_sel)
        SEL_RD:  r_output_port <= RETIRE_RD_WD;
        SEL_BR:  r_output_port <= {31'b0, RETIRE_BR_TAKEN};
        SEL_ST:  r_output_port <= RETIRE_MEM_ADDR;
        default: r_output_port <= r_output_port;
      endcase
    end
  end

  assign NUM_INST    = r_num_inst;
  assign OUTPUT_PORT = r_output_port;
  assign HALT        = w_halted;

endmodule

// File: tb/tb_riscv_retire_monitor.sv
// tb/tb_riscv_retire_monitor.sv - directed self-checking bench for riscv_retire_monitor
module tb_riscv_retire_monitor;

  logic        CLK;
  logic        RSTn;
  logic        RETIRE_VALID;
  logic [31:0] RETIRE_INST;
  logic        RETIRE_RD_WE;
  logic [4:0]  RETIRE_RD_WA;
  logic [31:0] RETIRE_RD_WD;
  logic        RETIRE_IS_BRANCH;
  logic        RETIRE_BR_TAKEN;
  logic        RETIRE_IS_STORE;
  logic [31:0] RETIRE_MEM_ADDR;
  logic [31:0] NUM_INST;
  logic [31:0] OUTPUT_PORT;
  logic        HALT;
  logic [3:0]  sat_num;
  logic [31:0] sat_out;
  logic        sat_halt;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I0  = 32'h00c00093;
  localparam logic [31:0] I1  = 32'h00008067;
  localparam logic [31:0] NOP = 32'h00000013;

  riscv_retire_monitor #(.CNT_WIDTH(32)) dut (
    .CLK(CLK), .RSTn(RSTn), .RETIRE_VALID(RETIRE_VALID), .RETIRE_INST(RETIRE_INST),
    .RETIRE_RD_WE(RETIRE_RD_WE), .RETIRE_RD_WA(RETIRE_RD_WA), .RETIRE_RD_WD(RETIRE_RD_WD),
    .RETIRE_IS_BRANCH(RETIRE_IS_BRANCH), .RETIRE_BR_TAKEN(RETIRE_BR_TAKEN),
    .RETIRE_IS_STORE(RETIRE_IS_STORE), .RETIRE_MEM_ADDR(RETIRE_MEM_ADDR),
    .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT)
  );

  riscv_retire_monitor #(.CNT_WIDTH(4)) dut_sat (
    .CLK(CLK), .RSTn(RSTn), .RETIRE_VALID(RETIRE_VALID), .RETIRE_INST(RETIRE_INST),
    .RETIRE_RD_WE(RETIRE_RD_WE), .RETIRE_RD_WA(RETIRE_RD_WA), .RETIRE_RD_WD(RETIRE_RD_WD),
    .RETIRE_IS_BRANCH(RETIRE_IS_BRANCH), .RETIRE_BR_TAKEN(RETIRE_BR_TAKEN),
    .RETIRE_IS_STORE(RETIRE_IS_STORE), .RETIRE_MEM_ADDR(RETIRE_MEM_ADDR),
    .NUM_INST(sat_num), .OUTPUT_PORT(sat_out), .HALT(sat_halt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    RETIRE_VALID = 1'b0; RETIRE_INST = 32'h0; RETIRE_RD_WE = 1'b0; RETIRE_RD_WA = 5'd0;
    RETIRE_RD_WD = 32'h0; RETIRE_IS_BRANCH = 1'b0; RETIRE_BR_TAKEN = 1'b0;
    RETIRE_IS_STORE = 1'b0; RETIRE_MEM_ADDR = 32'h0;
  endtask

  // Drives one record for one edge; returns 1 ns after that edge.
  task automatic retire(input logic [31:0] inst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic br, input logic tk,
                        input logic st, input logic [31:0] addr);
    RETIRE_VALID = 1'b1; RETIRE_INST = inst; RETIRE_RD_WE = we; RETIRE_RD_WA = wa;
    RETIRE_RD_WD = wd; RETIRE_IS_BRANCH = br; RETIRE_BR_TAKEN = tk;
    RETIRE_IS_STORE = st; RETIRE_MEM_ADDR = addr;
    @(posedge CLK); #1;
    idle_inputs();
  endtask

  task automatic bubble();
    idle_inputs();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    RSTn = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RSTn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (NUM_INST !== 32'd0) begin errors++; $display("FAIL rst_num got %0h exp 0", NUM_INST); end
    checks++; if (OUTPUT_PORT !== 32'd0) begin errors++; $display("FAIL rst_out got %0h exp 0", OUTPUT_PORT); end
    checks++; if (HALT !== 1'b0) begin errors++; $display("FAIL rst_halt got %0b exp 0", HALT); end
    RSTn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bubble();
      checks++;
      if (NUM_INST !== 32'd0 || OUTPUT_PORT !== 32'd0 || HALT !== 1'b0) begin
        errors++;
        $display("FAIL idle_%0d got num=%0h out=%0h halt=%0b exp 0/0/0", i, NUM_INST, OUTPUT_PORT, HALT);
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    retire(32'h0f000293, 1'b1, 5'd5, 32'h0f00, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (OUTPUT_PORT !== 32'h0f00 || NUM_INST !== 32'd1) begin errors++;
      $display("FAIL prio_rd got out=%0h num=%0d exp 0f00/1", OUTPUT_PORT, NUM_INST); end
    retire(32'h0002a023, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0ef0);
    checks++; if (OUTPUT_PORT !== 32'h0ef0 || NUM_INST !== 32'd2) begin errors++;
      $display("FAIL prio_st got out=%0h num=%0d exp 0ef0/2", OUTPUT_PORT, NUM_INST); end
    retire(32'h00000063, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (OUTPUT_PORT !== 32'h1 || NUM_INST !== 32'd3) begin errors++;
      $display("FAIL prio_br got out=%0h num=%0d exp 1/3", OUTPUT_PORT, NUM_INST); end
    retire(32'h00000023, 1'b1, 5'd0, 32'hdead, 1'b0, 1'b0, 1'b1, 32'h0eec);
    checks++; if (OUTPUT_PORT !== 32'h0eec || NUM_INST !== 32'd4) begin errors++;
      $display("FAIL prio_x0 got out=%0h num=%0d exp 0eec/4", OUTPUT_PORT, NUM_INST); end
    // Branch beats store; not-taken yields 0.
    retire(32'h00000063, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1234);
    checks++; if (OUTPUT_PORT !== 32'h0 || NUM_INST !== 32'd5) begin errors++;
      $display("FAIL prio_br_nt got out=%0h num=%0d exp 0/5", OUTPUT_PORT, NUM_INST); end
    retire(32'h0aa00313, 1'b1, 5'd6, 32'h00aa, 1'b1, 1'b1, 1'b1, 32'h5555);
    checks++; if (OUTPUT_PORT !== 32'h00aa || NUM_INST !== 32'd6) begin errors++;
      $display("FAIL prio_rd_all got out=%0h num=%0d exp aa/6", OUTPUT_PORT, NUM_INST); end
    retire(NOP, 1'b1, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (OUTPUT_PORT !== 32'h00aa || NUM_INST !== 32'd7) begin errors++;
      $display("FAIL prio_hold got out=%0h num=%0d exp aa/7", OUTPUT_PORT, NUM_INST); end
    bubble(); bubble();
    checks++; if (OUTPUT_PORT !== 32'h00aa || NUM_INST !== 32'd7 || HALT !== 1'b0) begin errors++;
      $display("FAIL prio_bubble got out=%0h num=%0d halt=%0b exp aa/7/0", OUTPUT_PORT, NUM_INST, HALT); end
  endtask

  task automatic test_halt_stalls();
    do_reset();
    retire(I0, 1'b1, 5'd1, 32'd12, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (HALT !== 1'b0 || NUM_INST !== 32'd1 || OUTPUT_PORT !== 32'h000c) begin errors++;
      $display("FAIL halt_first got halt=%0b num=%0d out=%0h exp 0/1/c", HALT, NUM_INST, OUTPUT_PORT); end
    for (int i = 0; i < 4; i++) begin
      bubble();
      checks++; if (HALT !== 1'b0) begin errors++; $display("FAIL halt_stall_%0d got %0b exp 0", i, HALT); end
    end
    retire(I1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (HALT !== 1'b1 || NUM_INST !== 32'd2 || OUTPUT_PORT !== 32'h000c) begin errors++;
      $display("FAIL halt_rise got halt=%0b num=%0d out=%0h exp 1/2/c", HALT, NUM_INST, OUTPUT_PORT); end
    for (int i = 0; i < 3; i++)
      retire(32'h05500193, 1'b1, 5'd3, 32'h55, 1'b1, 1'b1, 1'b1, 32'h77);
    checks++; if (HALT !== 1'b1 || NUM_INST !== 32'd2 || OUTPUT_PORT !== 32'h000c) begin errors++;
      $display("FAIL halt_frozen got halt=%0b num=%0d out=%0h exp 1/2/c", HALT, NUM_INST, OUTPUT_PORT); end
  endtask

  task automatic test_broken_idiom();
    do_reset();
    retire(I0, 1'b1, 5'd1, 32'd12, 1'b0, 1'b0, 1'b0, 32'h0);
    retire(NOP, 1'b1, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    retire(I1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (HALT !== 1'b0 || NUM_INST !== 32'd3) begin errors++;
      $display("FAIL broken_nop got halt=%0b num=%0d exp 0/3", HALT, NUM_INST); end
    do_reset();
    retire(I0, 1'b1, 5'd1, 32'd12, 1'b0, 1'b0, 1'b0, 32'h0);
    retire(I0, 1'b1, 5'd1, 32'd12, 1'b0, 1'b0, 1'b0, 32'h0);
    retire(I1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (HALT !== 1'b1 || NUM_INST !== 32'd3) begin errors++;
      $display("FAIL double_i0 got halt=%0b num=%0d exp 1/3", HALT, NUM_INST); end
  endtask

  task automatic test_async_reset();
    do_reset();
    retire(I0, 1'b1, 5'd1, 32'd12, 1'b0, 1'b0, 1'b0, 32'h0);
    #2 RSTn = 1'b0;
    #1;
    checks++; if (NUM_INST !== 32'd0 || OUTPUT_PORT !== 32'd0 || HALT !== 1'b0) begin errors++;
      $display("FAIL async_clear got num=%0d out=%0h halt=%0b exp 0/0/0", NUM_INST, OUTPUT_PORT, HALT); end
    #2 RSTn = 1'b1;
    @(posedge CLK); #1;
    retire(I1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (HALT !== 1'b0 || NUM_INST !== 32'd1) begin errors++;
      $display("FAIL lone_i1 got halt=%0b num=%0d exp 0/1", HALT, NUM_INST); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      retire(NOP, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (sat_num !== ((i > 15) ? 4'hf : 4'(i))) begin errors++;
        $display("FAIL sat_%0d got %0h exp %0h", i, sat_num, (i > 15) ? 4'hf : 4'(i)); end
    end
    checks++; if (NUM_INST !== 32'd20) begin errors++; $display("FAIL wide_count got %0d exp 20", NUM_INST); end
  endtask

  initial begin
    idle_inputs();
    RSTn = 1'b0;
    test_reset();
    test_priority();
    test_halt_stalls();
    test_broken_idiom();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
